// File: rtl/rvnoob_ifu.sv
// RVNoob instruction fetch: one outstanding imem read, holds the fetched word for decode,
// follows execute redirects and freezes on halt until reset.
module rvnoob_ifu #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            halted
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StHalt} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_d;
  logic            r_discard;
  logic            w_discard_d;
  logic [31:0]     r_inst;
  logic [31:0]     w_inst_d;
  logic [XLEN-1:0] w_redir_pc;

  assign w_redir_pc = redirect_pc & ~XLEN'(3);

  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_discard_d = r_discard;
    w_inst_d    = r_inst;
    if (halt) begin
      // Halt wins over everything; a concurrent out_ready still completes but pc stays.
      w_state_d = StHalt;
    end else begin
      case (r_state)
        StReq: begin
          if (imem_req_ready) begin
            w_state_d = StWait;
          end
          if (redirect_valid) begin
            w_pc_d      = w_redir_pc;
            w_discard_d = imem_req_ready;
          end
        end
        StWait: begin
          if (redirect_valid) begin
            w_pc_d = w_redir_pc;
            if (imem_resp_valid) begin
              w_state_d   = StReq;
              w_discard_d = 1'b0;
            end else begin
              w_discard_d = 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (r_discard) begin
              w_discard_d = 1'b0;
              w_state_d   = StReq;
            end else begin
              w_inst_d  = imem_resp_data;
              w_state_d = StHold;
            end
          end
        end
        StHold: begin
          if (redirect_valid) begin
            w_pc_d    = w_redir_pc;
            w_state_d = StReq;
          end else if (out_ready) begin
            w_pc_d    = r_pc + XLEN'(4);
            w_state_d = StReq;
          end
        end
        StHalt: begin
          w_state_d = StHalt;
        end
        default: begin
          w_state_d = StReq;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= StReq;
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
      r_inst    <= 32'h0;
    end else begin
      r_state   <= w_state_d;
      r_pc      <= w_pc_d;
      r_discard <= w_discard_d;
      r_inst    <= w_inst_d;
    end
  end

  assign imem_req_valid = (r_state == StReq) && !reset;
  assign imem_req_addr  = r_pc;
  assign out_valid      = (r_state == StHold) && !reset;
  assign out_pc         = r_pc;
  assign out_inst       = r_inst;
  assign halted         = (r_state == StHalt);

endmodule

// File: tb/tb_rvnoob_ifu.sv
// Bench for rvnoob_ifu: directed vector table, then randomized traffic against a
// transaction-level model with a behavioural instruction memory.
module tb_rvnoob_ifu;

  localparam logic [63:0] P = 64'h0000_0000_8000_0000;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        halted;

  rvnoob_ifu #(
    .XLEN    (64),
    .RESET_PC(P)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .halted         (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rdata;
    logic        redir;
    logic [63:0] rpc;
    logic        hlt, ordy;
    logic        e_req;
    logic [63:0] e_pc;
    logic        e_ov;
    logic [31:0] e_inst;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, rdy, rv, input logic [31:0] rdata, input logic redir,
                     input logic [63:0] rpc, input logic hlt, ordy, e_req,
                     input logic [63:0] e_pc, input logic e_ov, input logic [31:0] e_inst,
                     input logic e_halt);
    vec_t v;
    v = '{rst, rdy, rv, rdata, redir, rpc, hlt, ordy, e_req, e_pc, e_ov, e_inst, e_halt};
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Reference model state: transaction-level view of the fetch stage.
  logic [63:0] m_pc;
  logic [31:0] m_inst;
  bit          m_inflight, m_stale, m_have, m_halted;
  bit          exp_req, exp_ov, fired, got, s_req;
  logic [63:0] s_addr;
  // Behavioural memory.
  bit          mem_pend;
  int          mem_cnt;
  logic [63:0] mem_addr;

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; halt = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);

    //  rst rdy rv  rdata         redir rpc                    hlt ordy | req pc        ov inst  halted
    add(H, L, L, 32'h0,         L, 64'h0,                 L, L,   L, P,          L, 32'h0,         L);
    add(L, H, L, 32'h0,         L, 64'h0,                 L, L,   H, P,          L, 32'h0,         L);
    add(L, L, H, 32'h0000_0413, L, 64'h0,                 L, L,   L, P,          L, 32'h0,         L);
    add(L, L, L, 32'h0,         L, 64'h0,                 L, H,   L, P,          H, 32'h0000_0413, L);
    add(L, L, L, 32'h0,         L, 64'h0,                 L, L,   H, P + 4,      L, 32'h0000_0413, L);
    add(L, H, L, 32'h0,         L, 64'h0,                 L, L,   H, P + 4,      L, 32'h0000_0413, L);
    add(L, L, H, 32'h0010_0093, L, 64'h0,                 L, L,   L, P + 4,      L, 32'h0000_0413, L);
    for (int k = 0; k < 5; k++)
      add(L, L, L, 32'h0,       L, 64'h0,                 L, L,   L, P + 4,      H, 32'h0010_0093, L);
    add(L, L, L, 32'h0,         L, 64'h0,                 L, H,   L, P + 4,      H, 32'h0010_0093, L);
    add(L, H, L, 32'h0,         L, 64'h0,                 L, L,   H, P + 8,      L, 32'h0010_0093, L);
    // Redirect in WAIT, response two cycles later is discarded.
    add(L, L, L, 32'h0,         H, P + 64'h103,           L, L,   L, P + 8,      L, 32'h0010_0093, L);
    add(L, L, L, 32'h0,         L, 64'h0,                 L, L,   L, P + 64'h100, L, 32'h0010_0093, L);
    add(L, L, H, 32'hDEAD_BEEF, L, 64'h0,                 L, L,   L, P + 64'h100, L, 32'h0010_0093, L);
    add(L, H, L, 32'h0,         L, 64'h0,                 L, L,   H, P + 64'h100, L, 32'h0010_0093, L);
    // Redirect coincident with the response.
    add(L, L, H, 32'h1111_1111, H, P + 64'h208,           L, L,   L, P + 64'h100, L, 32'h0010_0093, L);
    add(L, H, L, 32'h0,         L, 64'h0,                 L, L,   H, P + 64'h208, L, 32'h0010_0093, L);
    add(L, L, H, 32'h0000_0513, L, 64'h0,                 L, L,   L, P + 64'h208, L, 32'h0010_0093, L);
    // Halt in HOLD with out_ready: pc frozen, later redirect ignored.
    add(L, L, L, 32'h0,         L, 64'h0,                 H, H,   L, P + 64'h208, H, 32'h0000_0513, L);
    add(L, H, H, 32'h0000_1234, H, P + 64'h400,           L, H,   L, P + 64'h208, L, 32'h0000_0513, H);
    add(L, H, L, 32'h0,         L, 64'h0,                 L, L,   L, P + 64'h208, L, 32'h0000_0513, H);
    add(H, L, L, 32'h0,         L, 64'h0,                 L, L,   L, P + 64'h208, L, 32'h0000_0513, H);
    // Reset pulsed in WAIT with pc = 0x80000040.
    add(L, L, L, 32'h0,         H, P + 64'h41,            L, L,   H, P,          L, 32'h0,         L);
    add(L, H, L, 32'h0,         L, 64'h0,                 L, L,   H, P + 64'h40, L, 32'h0,         L);
    add(H, L, L, 32'h0,         L, 64'h0,                 L, L,   L, P + 64'h40, L, 32'h0,         L);
    add(L, L, L, 32'h0,         L, 64'h0,                 L, L,   H, P,          L, 32'h0,         L);
    // pc wraps at the top of the address space.
    add(L, L, L, 32'h0,         H, 64'hFFFF_FFFF_FFFF_FFFE, L, L, H, P,          L, 32'h0,         L);
    add(L, H, L, 32'h0,         L, 64'h0,                 L, L,   H, 64'hFFFF_FFFF_FFFF_FFFC, L, 32'h0, L);
    add(L, L, H, 32'h0000_0013, L, 64'h0,                 L, L,   L, 64'hFFFF_FFFF_FFFF_FFFC, L, 32'h0, L);
    add(L, L, L, 32'h0,         L, 64'h0,                 L, H,   L, 64'hFFFF_FFFF_FFFF_FFFC, H, 32'h13, L);
    add(L, L, L, 32'h0,         L, 64'h0,                 L, L,   H, 64'h0,      L, 32'h0000_0013, L);
    add(L, H, L, 32'h0,         L, 64'h0,                 L, L,   H, 64'h0,      L, 32'h0000_0013, L);
    add(L, L, H, 32'h0020_0113, L, 64'h0,                 L, L,   L, 64'h0,      L, 32'h0000_0013, L);
    // Redirect in HOLD, without and with out_ready.
    add(L, L, L, 32'h0,         H, P + 64'h10,            L, L,   L, 64'h0,      H, 32'h0020_0113, L);
    add(L, H, L, 32'h0,         L, 64'h0,                 L, L,   H, P + 64'h10, L, 32'h0020_0113, L);
    add(L, L, H, 32'h0030_0193, L, 64'h0,                 L, L,   L, P + 64'h10, L, 32'h0020_0113, L);
    add(L, L, L, 32'h0,         H, P + 64'h20,            L, H,   L, P + 64'h10, H, 32'h0030_0193, L);
    add(L, L, L, 32'h0,         L, 64'h0,                 L, L,   H, P + 64'h20, L, 32'h0030_0193, L);

    foreach (vecs[i]) begin
      @(negedge clock);
      reset = vecs[i].rst; imem_req_ready = vecs[i].rdy; imem_resp_valid = vecs[i].rv;
      imem_resp_data = vecs[i].rdata; redirect_valid = vecs[i].redir;
      redirect_pc = vecs[i].rpc; halt = vecs[i].hlt; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("row%0d req_valid", i), 64'(imem_req_valid), 64'(vecs[i].e_req));
      chk($sformatf("row%0d req_addr", i), imem_req_addr, vecs[i].e_pc);
      chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("row%0d out_pc", i), out_pc, vecs[i].e_pc);
      chk($sformatf("row%0d out_inst", i), 64'(out_inst), 64'(vecs[i].e_inst));
      chk($sformatf("row%0d halted", i), 64'(halted), 64'(vecs[i].e_halt));
    end

    // Randomized traffic against the reference model.
    m_pc = P; m_inst = 32'h0; m_inflight = 0; m_stale = 0; m_have = 0; m_halted = 0;
    mem_pend = 0; mem_cnt = 0; mem_addr = 64'h0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      reset = (c == 0) || ($urandom % 300 == 0) || (m_halted && ($urandom % 10 == 0));
      if (mem_pend && mem_cnt == 0) begin
        imem_resp_valid = 1'b1; imem_resp_data = word(mem_addr);
      end else if (!mem_pend && ($urandom % 8 == 0)) begin
        imem_resp_valid = 1'b1; imem_resp_data = $urandom;
      end else begin
        imem_resp_valid = 1'b0; imem_resp_data = $urandom;
      end
      imem_req_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc    = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
      halt           = ($urandom % 250) == 0;
      out_ready      = ($urandom % 3) != 0;
      #1;
      exp_req = !reset && !m_halted && !m_inflight && !m_have;
      exp_ov  = !reset && m_have;
      if (c != 0) begin
        chk($sformatf("rnd%0d req_valid", c), 64'(imem_req_valid), 64'(exp_req));
        chk($sformatf("rnd%0d req_addr", c), imem_req_addr, m_pc);
        chk($sformatf("rnd%0d out_valid", c), 64'(out_valid), 64'(exp_ov));
        chk($sformatf("rnd%0d out_pc", c), out_pc, m_pc);
        chk($sformatf("rnd%0d out_inst", c), 64'(out_inst), 64'(m_inst));
        chk($sformatf("rnd%0d halted", c), 64'(halted), 64'(m_halted));
      end
      s_req  = imem_req_valid;
      s_addr = imem_req_addr;

      if (reset) begin
        m_pc = P; m_inst = 32'h0; m_inflight = 0; m_stale = 0; m_have = 0; m_halted = 0;
      end else if (!m_halted) begin
        if (halt) begin
          m_halted = 1; m_have = 0; m_inflight = 0;
        end else begin
          fired = exp_req && imem_req_ready;
          got   = m_inflight && imem_resp_valid;
          if (redirect_valid) begin
            m_pc       = {redirect_pc[63:2], 2'b00};
            m_have     = 0;
            m_inflight = fired || (m_inflight && !got);
            m_stale    = m_inflight;
          end else begin
            if (m_have && out_ready) begin
              m_pc   = m_pc + 64'd4;
              m_have = 0;
            end
            if (got) begin
              m_inflight = 0;
              if (m_stale) m_stale = 0;
              else begin
                m_have = 1;
                m_inst = imem_resp_data;
              end
            end
            if (fired) m_inflight = 1;
          end
        end
      end

      if (reset) begin
        mem_pend = 0;
      end else begin
        if (mem_pend && mem_cnt == 0 && imem_resp_valid) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (s_req && imem_req_ready) begin
          mem_pend = 1;
          mem_cnt  = int'($urandom % 3);
          mem_addr = s_addr;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
